// File: rtl/wide_add_seq_pkg.sv
// -----------------------------------------------------------------------------
// wide_add_seq_pkg
//   Shared types and constants for the wide_add_seq sequencer.
//   - state_t      : sequencer FSM states (IDLE, RUN, DONE)
//   - DEF_WIDTH    : default operand/result width
//   - DEF_N        : default chunk adder width
//   - calc_k       : number of chunks per operation (WIDTH / N)
//   - calc_idx_w   : width of the chunk counter (clog2(K), minimum 1)
// -----------------------------------------------------------------------------
package wide_add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 128;
    localparam int DEF_N     = 32;

    function automatic int calc_k(input int width, input int n);
        return width / n;
    endfunction

    // A single-chunk build still needs a 1-bit counter to keep the
    // declarations legal.
    function automatic int calc_idx_w(input int k);
        return (k <= 1) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/wide_add_seq_chunk_add.sv
// -----------------------------------------------------------------------------
// chunk_add
//   Purely combinational N-bit ripple-carry adder, organised as a chain of
//   4-bit ripple blocks. N must be a multiple of 4.
//
//   Ports:
//     Cin        in   1   carry into bit 0
//     operA      in   N   operand A
//     operB      in   N   operand B
//     resultOUT  out  N   sum bits
//     Cout       out  1   carry out of bit N-1
// -----------------------------------------------------------------------------
module chunk_add
    import wide_add_seq_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic         Cin,
    input  logic [N-1:0] operA,
    input  logic [N-1:0] operB,
    output logic [N-1:0] resultOUT,
    output logic         Cout
);

    if (N % 4 != 0) begin : gen_bad_n
        $error("chunk_add: N (%0d) must be a multiple of 4", N);
    end

    // c[i] is the carry into bit i; c[N] leaves the chunk.
    logic [N:0] c;

    assign c[0] = Cin;

    for (genvar g = 0; g < N / 4; g++) begin : gen_blk
        for (genvar b = 0; b < 4; b++) begin : gen_bit
            localparam int I = 4 * g + b;
            logic p;
            assign p            = operA[I] ^ operB[I];
            assign resultOUT[I] = p ^ c[I];
            assign c[I+1]       = (operA[I] & operB[I]) | (p & c[I]);
        end
    end

    assign Cout = c[N];

endmodule

// File: rtl/wide_add_seq.sv
// -----------------------------------------------------------------------------
// wide_add_seq
//   Multi-cycle WIDTH-bit adder built on a single N-bit ripple-carry chunk
//   adder. Each accepted operation is processed LS chunk first over
//   K = WIDTH/N cycles, with the chunk carry registered between cycles.
//
//   Optional feature macro: WIDE_ADD_SEQ_SUB_EN
//     When defined, an op_sub input selects opA - opB (B inverted per chunk,
//     carry preset to 1). Cout = 1 then means "no borrow".
//
//   Ports:
//     clk        in   1      rising-edge clock
//     rst        in   1      synchronous active-high reset
//     in_valid   in   1      operands valid
//     in_ready   out  1      block can accept (IDLE only)
//     opA        in   WIDTH  operand A
//     opB        in   WIDTH  operand B
//     Cin        in   1      carry into chunk 0
//     op_sub     in   1      subtract select (WIDE_ADD_SEQ_SUB_EN only)
//     out_valid  out  1      result valid (DONE only)
//     out_ready  in   1      consumer accepts result
//     resultOUT  out  WIDTH  sum
//     Cout       out  1      carry out of the top chunk
//     busy       out  1      high in RUN or DONE
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for in_valid; operands captured on accept
//   RUN   | one chunk added per cycle, idx counts 0..K-1
//   DONE  | result and carry held until out_ready
// -----------------------------------------------------------------------------
module wide_add_seq
    import wide_add_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             Cin,
`ifdef WIDE_ADD_SEQ_SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] resultOUT,
    output logic             Cout,
    output logic             busy
);

    localparam int K     = calc_k(WIDTH, N);
    localparam int IDX_W = calc_idx_w(K);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(K - 1);

    if ((WIDTH % N != 0) || (N % 4 != 0)) begin : gen_bad_cfg
        $error("wide_add_seq: WIDTH (%0d) must be a multiple of N (%0d), N a multiple of 4",
               WIDTH, N);
    end

    state_t state;
    state_t state_next;

    logic accept;
    logic run_step;
    logic last_chunk;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic             carry_load;
    logic [IDX_W-1:0] idx;

    logic             sub_sel;
    logic [N-1:0]     b_chunk;
    logic [N-1:0]     chunk_sum;
    logic             chunk_cout;

    // ------------------------------------------------------------------
    // Optional subtract path
    // ------------------------------------------------------------------
`ifdef WIDE_ADD_SEQ_SUB_EN
    logic sub_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sub_q <= 1'b0;
        end else if (accept) begin
            sub_q <= op_sub;
        end
    end

    assign sub_sel    = sub_q;
    assign carry_load = op_sub ? 1'b1 : Cin;
`else
    assign sub_sel    = 1'b0;
    assign carry_load = Cin;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    assign last_chunk = (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        run_step   = 1'b0;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy     = 1'b1;
                run_step = 1'b1;
                if (last_chunk) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Chunk adder and result assembly
    // ------------------------------------------------------------------
    assign b_chunk = b_sr[N-1:0] ^ {N{sub_sel}};

    chunk_add #(
        .N (N)
    ) u_chunk_add (
        .Cin       (carry),
        .operA     (a_sr[N-1:0]),
        .operB     (b_chunk),
        .resultOUT (chunk_sum),
        .Cout      (chunk_cout)
    );

    // New chunk sums enter at the top; after K steps chunk 0 has reached
    // the bottom of the register.
    if (K == 1) begin : gen_res_single
        assign res_next = chunk_sum;
    end else begin : gen_res_multi
        assign res_next = {chunk_sum, res_sr[WIDTH-1:N]};
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            idx    <= '0;
        end else if (accept) begin
            a_sr  <= opA;
            b_sr  <= opB;
            carry <= carry_load;
            idx   <= '0;
        end else if (run_step) begin
            a_sr   <= a_sr >> N;
            b_sr   <= b_sr >> N;
            res_sr <= res_next;
            carry  <= chunk_cout;
            // Hold on the final chunk so idx never wraps inside an operation.
            if (!last_chunk) begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign resultOUT = res_sr;
    assign Cout      = carry;

endmodule

// File: tb/tb_wide_add_seq.sv
module tb_wide_add_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] opA;
    logic [127:0] opB;
    logic         Cin;
`ifdef WIDE_ADD_SEQ_SUB_EN
    logic         op_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [127:0] resultOUT;
    logic         Cout;
    logic         busy;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wide_add_seq #(
        .WIDTH (128),
        .N     (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opA       (opA),
        .opB       (opB),
        .Cin       (Cin),
`ifdef WIDE_ADD_SEQ_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .resultOUT (resultOUT),
        .Cout      (Cout),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operation; in_valid drops after the accept edge.
    // Returns the number of edges (accept edge = 1) until out_valid is seen.
    task automatic run_op(input logic [127:0] a, input logic [127:0] b, input logic c,
                          input logic corrupt, output int edges);
        opA      = a;
        opB      = b;
        Cin      = c;
        in_valid = 1'b1;
        edges    = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 1) begin
                in_valid = 1'b0;
                if (corrupt) begin
                    opA = ~a;
                    opB = ~b;
                    Cin = ~c;
                end
            end
            if (out_valid) begin
                edges = n;
                break;
            end
        end
    endtask

    int           edges;
    logic [127:0] hold_res;
    logic         hold_cout;
    int           acc_edge [3];
    logic [127:0] got [3];
    logic [127:0] ops_a [3];
    logic [127:0] ops_b [3];
    logic         ops_c [3];
    int           n_acc;
    int           n_res;
    logic         accepting;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opA       = '0;
        opB       = '0;
        Cin       = 1'b0;
`ifdef WIDE_ADD_SEQ_SUB_EN
        op_sub    = 1'b0;
`endif
        tick();
        tick();
        chk("reset_in_ready", 128'(in_ready), 128'd1);
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_result", resultOUT, 128'd0);
        chk("reset_cout", 128'(Cout), 128'd0);
        rst = 1'b0;
        tick();

        // Carry ripples through every chunk; operands scrambled after accept.
        run_op({128{1'b1}}, 128'd1, 1'b0, 1'b1, edges);
        chk("carry_all_latency", 128'(edges), 128'd5);
        chk("carry_all_result", resultOUT, 128'd0);
        chk("carry_all_cout", 128'(Cout), 128'd1);
        chk("carry_all_busy", 128'(busy), 128'd1);
        chk("carry_all_in_ready", 128'(in_ready), 128'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("handoff_in_ready", 128'(in_ready), 128'd1);
        chk("handoff_out_valid", 128'(out_valid), 128'd0);

        // Carry crossing into chunk 3 only.
        run_op(128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd0, 1'b1, 1'b0, edges);
        chk("mid_carry_result", resultOUT, 128'h00000001_00000000_00000000_00000000);
        chk("mid_carry_cout", 128'(Cout), 128'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Backpressure: three cycles stalled in DONE with in_valid held high.
        run_op(128'h01234567_89ABCDEF_FEDCBA98_76543210,
               128'h11111111_11111111_11111111_11111111, 1'b0, 1'b0, edges);
        chk("bp_result", resultOUT, 128'h12345678_9ABCDF01_0FEDCBA9_87654321);
        chk("bp_cout", 128'(Cout), 128'd0);
        hold_res  = resultOUT;
        hold_cout = Cout;
        in_valid  = 1'b1;
        opA       = 128'd77;
        opB       = 128'd99;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_stable_result", resultOUT, hold_res);
            chk("bp_stable_cout", 128'(Cout), 128'(hold_cout));
            chk("bp_in_ready", 128'(in_ready), 128'd0);
            chk("bp_out_valid", 128'(out_valid), 128'd1);
        end
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("bp_release_in_ready", 128'(in_ready), 128'd1);
        chk("bp_release_out_valid", 128'(out_valid), 128'd0);

        // Reset two cycles into RUN.
        opA      = {128{1'b1}};
        opB      = {128{1'b1}};
        Cin      = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_out_valid", 128'(out_valid), 128'd0);
        chk("abort_result", resultOUT, 128'd0);
        chk("abort_in_ready", 128'(in_ready), 128'd1);
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_cout", 128'(Cout), 128'd0);
        run_op(128'd5, 128'd3, 1'b0, 1'b0, edges);
        chk("after_abort_latency", 128'(edges), 128'd5);
        chk("after_abort_result", resultOUT, 128'd8);
        chk("after_abort_cout", 128'(Cout), 128'd0);
        out_ready = 1'b1;
        tick();

        // Back-to-back with in_valid and out_ready held high.
        ops_a[0] = 128'd1;             ops_b[0] = 128'd2;             ops_c[0] = 1'b0;
        ops_a[1] = 128'd10;            ops_b[1] = 128'd20;            ops_c[1] = 1'b0;
        ops_a[2] = {128{1'b1}};        ops_b[2] = {128{1'b1}};        ops_c[2] = 1'b1;
        n_acc = 0;
        n_res = 0;
        opA = ops_a[0];
        opB = ops_b[0];
        Cin = ops_c[0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int e = 0; e < 40 && n_res < 3; e++) begin
            accepting = in_ready & in_valid;
            if (out_valid) begin
                got[n_res] = resultOUT;
                n_res++;
            end
            tick();
            if (accepting && n_acc < 3) begin
                acc_edge[n_acc] = e;
                n_acc++;
                if (n_acc < 3) begin
                    opA = ops_a[n_acc];
                    opB = ops_b[n_acc];
                    Cin = ops_c[n_acc];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b_accepts", 128'(n_acc), 128'd3);
        chk("b2b_results", 128'(n_res), 128'd3);
        if (n_acc == 3) begin
            chk("b2b_gap_1", 128'(acc_edge[1] - acc_edge[0]), 128'd6);
            chk("b2b_gap_2", 128'(acc_edge[2] - acc_edge[1]), 128'd6);
        end
        if (n_res == 3) begin
            chk("b2b_res_0", got[0], 128'd3);
            chk("b2b_res_1", got[1], 128'd30);
            chk("b2b_res_2", got[2], {128{1'b1}});
        end
        tick();

`ifdef WIDE_ADD_SEQ_SUB_EN
        op_sub = 1'b1;
        run_op(128'd5, 128'd7, 1'b0, 1'b0, edges);
        op_sub = 1'b0;
        chk("sub_result", resultOUT, {{127{1'b1}}, 1'b0});
        chk("sub_cout", 128'(Cout), 128'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
